multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control unit for the RV32I core: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back. It drives the datapath mux selects and write enables, and handshakes with a shared instruction/data memory of variable latency. It supports R/I-type, LW, SW, BEQ-class branches, JAL, JALR and, when enabled, LUI/AUIPC. It adds an illegal-opcode trap, a memory-timeout trap and a retired-instruction counter.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles spent waiting for `mem_ready` in one memory state; legal range ≥1.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `EN_UPPER`, default 1: 1 means LUI (0110111) and AUIPC (0010111) are legal; 0 means they trap as illegal.
- `clk  in  1`: clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `opcode  in  7`: opcode field of the instruction register; sampled in DECODE only.
- `mem_ready  in  1`: memory completes the current access this cycle.
- `mem_req  out  1`: memory access request.
- `mem_we  out  1`: write access; only ever asserted together with `mem_req`.
- `addr_sel  out  1`: memory address source. 0 = PC, 1 = ALU result register.
- `ir_write  out  1`: load the instruction register and old-PC register.
- `pc_write  out  1`: load the PC.
- `reg_write  out  1`: register file write enable.
- `alu_src_a  out  2`: ALU operand A. 00 = PC, 01 = old PC, 10 = rs1, 11 = zero.
- `alu_src_b  out  2`: ALU operand B. 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op  out  2`: 00 = add, 01 = branch compare/sub, 10 = funct-decoded.
- `result_src  out  2`: result bus source. 00 = ALU result register, 01 = memory read data, 10 = ALU direct.
- `branch  out  1`: PC load is conditional on the ALU zero/compare flag.
- `trap  out  1`: sticky; the core has halted.
- `trap_cause  out  2`: 00 = none, 01 = illegal opcode, 10 = memory timeout.
- `retired  out  CNT_W`: count of completed instructions.

## Operation
- **States:** IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP.
- **Reset:** async to IDLE; all outputs 0; `retired` = 0; `trap_cause` = 00.
- **IDLE → FETCH:** unconditionally, on the first edge after `rst_n` rises.
- **FETCH:**
  - Drives `mem_req`=1, `addr_sel`=0.
  - While `mem_ready`=0, holds state with `ir_write` and `pc_write` = 0.
  - In the `mem_ready`=1 cycle, also drives `ir_write`=1, `pc_write`=1, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10 (PC ← PC+4). Next state is DECODE.
- **DECODE:**
  - Drives `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (target = old PC + imm).
  - Dispatches on `opcode`: LW/SW → MEMADR, 0110011 → EXEC_R, 0010011 → EXEC_I, 1100011 → BRANCH, 1101111 → JAL, 1100111 → JALR, LUI/AUIPC → UPPER (only if `EN_UPPER`).
  - Any other opcode → TRAP with cause 01.
- **MEMADR:** `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next state is MEMRD for LW, MEMWR for SW.
- **MEMRD:** `mem_req`=1, `addr_sel`=1. Waits for `mem_ready`, then → MEMWB.
- **MEMWB:** `result_src`=01, `reg_write`=1. Retires; → FETCH.
- **MEMWR:** `mem_req`=1, `mem_we`=1, `addr_sel`=1. Retires in the `mem_ready` cycle; → FETCH.
- **EXEC_R / EXEC_I:** `alu_src_a`=10, `alu_src_b`=00 or 01 respectively, `alu_op`=10. Next state is ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`=1. Retires; → FETCH.
- **BRANCH:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1. Retires; → FETCH.
- **JAL:**
  - `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00: rd ← old PC+4 via `result_src`=10, `reg_write`=1.
  - `pc_write`=1 with PC ← target via a separate PC-source path held in the ALU result register.
  - Retires; → FETCH.
- **JALR:** MEMADR-style address computation (`alu_src_a`=10, `alu_src_b`=01), then behaves as JAL. Retires; → FETCH.
- **UPPER:** `alu_src_a`=11 (LUI) or 01 (AUIPC), `alu_src_b`=01, `alu_op`=00. Next state is ALUWB.
- **TRAP:** all enables 0; absorbing until reset. `trap`=1 from the first TRAP cycle.
- **Retire rule:** `retired` increments by 1 on the edge leaving each retiring state. It wraps modulo 2^CNT_W; no saturation.

## Timing
- Cycle counts below assume zero wait states:
  - R/I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
  - JAL/JALR: 3 cycles.
  - LUI/AUIPC: 4 cycles.
- Each wait cycle adds 1.
- **Wait counter:** cleared on entry to FETCH, MEMRD and MEMWR. It increments each cycle `mem_ready`=0.
- **Timeout:** reaching `MEM_TIMEOUT` with `mem_ready`=0 → TRAP with cause 10 on the next edge.
- **Simultaneous events:** `mem_ready`=1 in the same cycle the limit is reached means completion wins; no trap.
- **Output timing:** all outputs are combinational from the registered state plus `mem_ready`. No output depends on `opcode` outside DECODE, JALR and UPPER.
- **Reset mid-access:** all outputs drop asynchronously. No partial retire is counted.

## Structure
- **Package `riscv_ctrl_pkg`:**
  - Opcode localparams (R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR, LUI, AUIPC).
  - State enum `ctrl_state_t`.
  - Encodings for `alu_src_a`/`alu_src_b`/`result_src`/`alu_op`/`trap_cause`.
- **Sub-module `mem_wait_timer`:** parameter `MEM_TIMEOUT`; inputs `clk`, `rst_n`, `clear`, `ready`; output `expired`.
- **Counter:** `retired` is inline in the top module.

## Test plan
- Reset, then opcode 0110011 with `mem_ready` tied 1 → FETCH, DECODE, EXEC_R, ALUWB; `reg_write`=1 in cycle 4 only; `retired`=1.
- LW with 2 wait states on the data read → MEMRD lasts 3 cycles; total 7 cycles; `result_src`=01 in MEMWB.
- Opcode 0000000 → TRAP after DECODE; `trap_cause`=01; no `reg_write` or `mem_req` afterwards for 20 cycles.
- `EN_UPPER`=0 with opcode 0110111 → `trap_cause`=01; `EN_UPPER`=1 with the same opcode → retires in 4 cycles.
- `MEM_TIMEOUT`=4 with `mem_ready` held 0 in FETCH → TRAP on the 5th cycle, cause 10. Repeat with `mem_ready`=1 exactly on the 4th wait cycle → no trap.
- `CNT_W`=4, run 17 branches → `retired`=1 (wrap). Pulse `rst_n` low mid-MEMRD → outputs 0 immediately, `retired`=0, state IDLE.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit: opcodes,
// FSM state encoding and datapath select encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
        ST_EXEC_R, ST_EXEC_I, ST_ALUWB, ST_BRANCH, ST_JAL, ST_JALR, ST_UPPER,
        ST_TRAP
    } ctrl_state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that issue a memory request and therefore run the wait timer.
    function automatic logic is_mem_state(input ctrl_state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for memory in one access; flags the cycle in
// which the MEM_TIMEOUT-th consecutive wait happens.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic ready,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Wait counter: cleared on entry to a memory state, saturates at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (!ready && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // A ready in the limit cycle completes the access, so it masks expiry.
    assign expired = !ready && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and write-back, with illegal-opcode and memory-timeout traps
// and a retired-instruction counter.
//
// Memory handshake: mem_req is held high for the whole access; the access
// completes in the cycle where mem_req and mem_ready are both 1. mem_req never
// drops before completion unless the wait timer expires (trap) or reset hits.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter bit EN_UPPER    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             branch,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired,
    output ctrl_state_t      dbg_state
);

    ctrl_state_t      state_q, state_d;
    logic [1:0]       trap_cause_q;
    logic [CNT_W-1:0] retired_q;
    logic             is_store_q;
    logic             is_lui_q;
    logic             retire;
    logic             cause_set;
    logic [1:0]       cause_val;
    logic             timer_clear;
    logic             timer_expired;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .ready   (mem_ready),
        .expired (timer_expired)
    );

    // Restart the wait count whenever a memory state is freshly entered.
    always_comb begin
        timer_clear = (state_d != state_q) && is_mem_state(state_d);
    end

    // State, trap cause, retire counter and decode flags (opcode is only
    // trusted in DECODE, so LW/SW and LUI/AUIPC are remembered here).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            trap_cause_q <= CAUSE_NONE;
            retired_q    <= '0;
            is_store_q   <= 1'b0;
            is_lui_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cause_set) trap_cause_q <= cause_val;
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (state_q == ST_DECODE) begin
                is_store_q <= (opcode == SW);
                is_lui_q   <= (opcode == LUI);
            end
        end
    end

    // Next-state logic and Moore outputs (FETCH/MEMRD/MEMWR also see mem_ready).
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        branch     = 1'b0;
        trap       = 1'b0;
        retire     = 1'b0;
        cause_set  = 1'b0;
        cause_val  = CAUSE_NONE;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    alu_op     = ALUOP_ADD;
                    result_src = RES_ALU;
                    state_d    = ST_DECODE;
                end else if (timer_expired) begin
                    state_d   = ST_TRAP;
                    cause_set = 1'b1;
                    cause_val = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    LW, SW:  state_d = ST_MEMADR;
                    R_TYPE:  state_d = ST_EXEC_R;
                    I_TYPE:  state_d = ST_EXEC_I;
                    BR:      state_d = ST_BRANCH;
                    JAL:     state_d = ST_JAL;
                    JALR:    state_d = ST_JALR;
                    LUI, AUIPC: begin
                        if (EN_UPPER) begin
                            state_d = ST_UPPER;
                        end else begin
                            state_d   = ST_TRAP;
                            cause_set = 1'b1;
                            cause_val = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d   = ST_TRAP;
                        cause_set = 1'b1;
                        cause_val = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = is_store_q ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end else if (timer_expired) begin
                    state_d   = ST_TRAP;
                    cause_set = 1'b1;
                    cause_val = CAUSE_TIMEOUT;
                end
            end
            ST_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (timer_expired) begin
                    state_d   = ST_TRAP;
                    cause_set = 1'b1;
                    cause_val = CAUSE_TIMEOUT;
                end
            end
            ST_EXEC_R, ST_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = (state_q == ST_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = ST_ALUWB;
            end
            ST_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_JAL, ST_JALR: begin
                // JAL links old PC + 4; JALR drives the rs1 + imm target
                // through the ALU while the link travels the same bus.
                alu_src_a  = (state_q == ST_JAL) ? SRCA_OLDPC : SRCA_RS1;
                alu_src_b  = (state_q == ST_JAL) ? SRCB_FOUR : SRCB_IMM;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALU;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_UPPER: begin
                alu_src_a = is_lui_q ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = ST_ALUWB;
            end
            ST_TRAP: trap = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    assign trap_cause = trap_cause_q;
    assign retired    = retired_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instance A (MEM_TIMEOUT=4,
// CNT_W=4, EN_UPPER=1) carries most scenarios, instance B (EN_UPPER=0)
// covers the disabled LUI/AUIPC trap.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    localparam int W = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A ----------------
    logic [6:0] a_opcode;
    logic       a_ready;
    logic       a_mem_req, a_mem_we, a_addr_sel, a_ir_write, a_pc_write, a_reg_write;
    logic [1:0] a_src_a, a_src_b, a_alu_op, a_res, a_cause;
    logic       a_branch, a_trap;
    logic [3:0] a_retired;
    ctrl_state_t a_state;

    multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(4), .EN_UPPER(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(a_opcode), .mem_ready(a_ready),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .addr_sel(a_addr_sel),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
        .alu_src_a(a_src_a), .alu_src_b(a_src_b), .alu_op(a_alu_op),
        .result_src(a_res), .branch(a_branch), .trap(a_trap),
        .trap_cause(a_cause), .retired(a_retired), .dbg_state(a_state)
    );

    // ---------------- DUT B ----------------
    logic [6:0] b_opcode;
    logic       b_ready;
    logic       b_mem_req, b_mem_we, b_addr_sel, b_ir_write, b_pc_write, b_reg_write;
    logic [1:0] b_src_a, b_src_b, b_alu_op, b_res, b_cause;
    logic       b_branch, b_trap;
    logic [31:0] b_retired;
    ctrl_state_t b_state;

    multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(32), .EN_UPPER(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(b_opcode), .mem_ready(b_ready),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .addr_sel(b_addr_sel),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
        .alu_src_a(b_src_a), .alu_src_b(b_src_b), .alu_op(b_alu_op),
        .result_src(b_res), .branch(b_branch), .trap(b_trap),
        .trap_cause(b_cause), .retired(b_retired), .dbg_state(b_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    // Expected control vector for a state, straight from the state table.
    function automatic logic [W-1:0] model(input ctrl_state_t s, input logic rdy, input logic lui);
        logic mreq, mwe, asel, irw, pcw, rw, br, tr;
        logic [1:0] sa, sb, op, rs;
        mreq = 0; mwe = 0; asel = 0; irw = 0; pcw = 0; rw = 0; br = 0; tr = 0;
        sa = 2'b00; sb = 2'b00; op = 2'b00; rs = 2'b00;
        case (s)
            ST_FETCH: begin
                mreq = 1;
                if (rdy) begin irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10; end
            end
            ST_DECODE: begin sa = 2'b01; sb = 2'b01; end
            ST_MEMADR: begin sa = 2'b10; sb = 2'b01; end
            ST_MEMRD:  begin mreq = 1; asel = 1; end
            ST_MEMWB:  begin rs = 2'b01; rw = 1; end
            ST_MEMWR:  begin mreq = 1; mwe = 1; asel = 1; end
            ST_EXEC_R: begin sa = 2'b10; sb = 2'b00; op = 2'b10; end
            ST_EXEC_I: begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
            ST_ALUWB:  begin rs = 2'b00; rw = 1; end
            ST_BRANCH: begin sa = 2'b10; sb = 2'b00; op = 2'b01; br = 1; end
            ST_JAL:    begin sa = 2'b01; sb = 2'b10; rs = 2'b10; rw = 1; pcw = 1; end
            ST_JALR:   begin sa = 2'b10; sb = 2'b01; rs = 2'b10; rw = 1; pcw = 1; end
            ST_UPPER:  begin sa = lui ? 2'b11 : 2'b01; sb = 2'b01; end
            ST_TRAP:   tr = 1;
            default: ;
        endcase
        return {4'(s), mreq, mwe, asel, irw, pcw, rw, sa, sb, op, rs, br, tr};
    endfunction

    function automatic logic [W-1:0] pack_a();
        return {4'(a_state), a_mem_req, a_mem_we, a_addr_sel, a_ir_write, a_pc_write,
                a_reg_write, a_src_a, a_src_b, a_alu_op, a_res, a_branch, a_trap};
    endfunction

    function automatic logic [W-1:0] pack_b();
        return {4'(b_state), b_mem_req, b_mem_we, b_addr_sel, b_ir_write, b_pc_write,
                b_reg_write, b_src_a, b_src_b, b_alu_op, b_res, b_branch, b_trap};
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic check_vec(input string tag, input logic [W-1:0] got);
        logic [W-1:0] exp;
        exp = exp_q.pop_front();
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One cycle on A: drive inputs after the edge, then check the state entered.
    task automatic cyc_a(input logic rdy, input logic [6:0] op, input ctrl_state_t es, input string tag);
        @(posedge clk);
        #2;
        a_ready = rdy;
        a_opcode = op;
        #1;
        exp_q.push_back(model(es, rdy, op == LUI));
        check_vec(tag, pack_a());
    endtask

    task automatic cyc_b(input logic rdy, input logic [6:0] op, input ctrl_state_t es, input string tag);
        @(posedge clk);
        #2;
        b_ready = rdy;
        b_opcode = op;
        #1;
        exp_q.push_back(model(es, rdy, 1'b0));
        check_vec(tag, pack_b());
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(model(ST_IDLE, 1'b0, 1'b0));
        check_vec(tag, pack_a());
        check_val({tag, "_retired"}, 32'(a_retired), 32'd0);
        check_val({tag, "_cause"}, 32'(a_cause), 32'(CAUSE_NONE));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        a_ready = 1'b0; a_opcode = 7'd0;
        b_ready = 1'b0; b_opcode = 7'd0;
        #3;
        do_reset("reset0");

        // B: LUI with upper ops disabled traps as illegal.
        // Meanwhile A waits in FETCH with mem_ready low and must time out.
        cyc_b(1'b1, rnd_op(), ST_FETCH, "b_fetch");
        cyc_b(1'b1, LUI, ST_DECODE, "b_decode_lui");
        cyc_b(1'b1, rnd_op(), ST_TRAP, "b_trap");
        check_val("b_cause", 32'(b_cause), 32'(CAUSE_ILLEGAL));
        b_ready = 1'b0;
        cyc_a(1'b0, rnd_op(), ST_FETCH, "a_fetch_wait4");
        cyc_a(1'b1, rnd_op(), ST_TRAP, "a_fetch_timeout");
        check_val("a_cause_timeout", 32'(a_cause), 32'(CAUSE_TIMEOUT));
        cyc_a(1'b1, rnd_op(), ST_TRAP, "a_trap_hold");

        do_reset("reset1");
        // R-type, zero wait states
        cyc_a(1'b1, rnd_op(), ST_FETCH, "r_fetch");
        cyc_a(1'b1, R_TYPE, ST_DECODE, "r_decode");
        cyc_a(1'b1, rnd_op(), ST_EXEC_R, "r_exec");
        cyc_a(1'b1, rnd_op(), ST_ALUWB, "r_wb");
        // LW with two data wait states
        cyc_a(1'b1, rnd_op(), ST_FETCH, "lw_fetch");
        check_val("ret_r", 32'(a_retired), 32'd1);
        cyc_a(1'b1, LW, ST_DECODE, "lw_decode");
        cyc_a(1'b1, rnd_op(), ST_MEMADR, "lw_memadr");
        cyc_a(1'b0, rnd_op(), ST_MEMRD, "lw_memrd_w1");
        cyc_a(1'b0, rnd_op(), ST_MEMRD, "lw_memrd_w2");
        cyc_a(1'b1, rnd_op(), ST_MEMRD, "lw_memrd_done");
        cyc_a(1'b1, rnd_op(), ST_MEMWB, "lw_memwb");
        // SW with one fetch wait and one write wait
        cyc_a(1'b0, rnd_op(), ST_FETCH, "sw_fetch_w");
        check_val("ret_lw", 32'(a_retired), 32'd2);
        cyc_a(1'b1, rnd_op(), ST_FETCH, "sw_fetch");
        cyc_a(1'b1, SW, ST_DECODE, "sw_decode");
        cyc_a(1'b1, rnd_op(), ST_MEMADR, "sw_memadr");
        cyc_a(1'b0, rnd_op(), ST_MEMWR, "sw_memwr_w");
        cyc_a(1'b1, rnd_op(), ST_MEMWR, "sw_memwr_done");
        // I-type
        cyc_a(1'b1, rnd_op(), ST_FETCH, "i_fetch");
        check_val("ret_sw", 32'(a_retired), 32'd3);
        cyc_a(1'b1, I_TYPE, ST_DECODE, "i_decode");
        cyc_a(1'b1, rnd_op(), ST_EXEC_I, "i_exec");
        cyc_a(1'b1, rnd_op(), ST_ALUWB, "i_wb");
        // branch, JAL, JALR
        cyc_a(1'b1, rnd_op(), ST_FETCH, "br_fetch");
        check_val("ret_i", 32'(a_retired), 32'd4);
        cyc_a(1'b1, BR, ST_DECODE, "br_decode");
        cyc_a(1'b1, rnd_op(), ST_BRANCH, "br_exec");
        cyc_a(1'b1, rnd_op(), ST_FETCH, "jal_fetch");
        check_val("ret_br", 32'(a_retired), 32'd5);
        cyc_a(1'b1, JAL, ST_DECODE, "jal_decode");
        cyc_a(1'b1, rnd_op(), ST_JAL, "jal_exec");
        cyc_a(1'b1, rnd_op(), ST_FETCH, "jalr_fetch");
        check_val("ret_jal", 32'(a_retired), 32'd6);
        cyc_a(1'b1, JALR, ST_DECODE, "jalr_decode");
        cyc_a(1'b1, JALR, ST_JALR, "jalr_exec");
        // LUI and AUIPC
        cyc_a(1'b1, rnd_op(), ST_FETCH, "lui_fetch");
        check_val("ret_jalr", 32'(a_retired), 32'd7);
        cyc_a(1'b1, LUI, ST_DECODE, "lui_decode");
        cyc_a(1'b1, LUI, ST_UPPER, "lui_upper");
        cyc_a(1'b1, rnd_op(), ST_ALUWB, "lui_wb");
        cyc_a(1'b1, rnd_op(), ST_FETCH, "auipc_fetch");
        check_val("ret_lui", 32'(a_retired), 32'd8);
        cyc_a(1'b1, AUIPC, ST_DECODE, "auipc_decode");
        cyc_a(1'b1, AUIPC, ST_UPPER, "auipc_upper");
        cyc_a(1'b1, rnd_op(), ST_ALUWB, "auipc_wb");
        // ready arrives on the 4th wait cycle: completion wins over timeout
        cyc_a(1'b0, rnd_op(), ST_FETCH, "edge_w1");
        check_val("ret_auipc", 32'(a_retired), 32'd9);
        cyc_a(1'b0, rnd_op(), ST_FETCH, "edge_w2");
        cyc_a(1'b0, rnd_op(), ST_FETCH, "edge_w3");
        cyc_a(1'b1, rnd_op(), ST_FETCH, "edge_ready4");
        cyc_a(1'b1, R_TYPE, ST_DECODE, "edge_decode");
        cyc_a(1'b1, rnd_op(), ST_EXEC_R, "edge_exec");
        cyc_a(1'b1, rnd_op(), ST_ALUWB, "edge_wb");
        // LW interrupted by reset mid-MEMRD
        cyc_a(1'b1, rnd_op(), ST_FETCH, "rst_fetch");
        check_val("ret_edge", 32'(a_retired), 32'd10);
        check_val("cause_none", 32'(a_cause), 32'(CAUSE_NONE));
        cyc_a(1'b1, LW, ST_DECODE, "rst_decode");
        cyc_a(1'b1, rnd_op(), ST_MEMADR, "rst_memadr");
        cyc_a(1'b0, rnd_op(), ST_MEMRD, "rst_memrd");
        a_ready = 1'b1;
        #1;
        do_reset("reset_mid_memrd");

        // 17 branches wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            cyc_a(1'b1, rnd_op(), ST_FETCH, "wrap_fetch");
            cyc_a(1'b1, BR, ST_DECODE, "wrap_decode");
            cyc_a(1'b1, rnd_op(), ST_BRANCH, "wrap_branch");
        end
        // fetch waits must not leak into the MEMRD wait budget
        cyc_a(1'b0, rnd_op(), ST_FETCH, "to_fetch_w1");
        check_val("ret_wrap", 32'(a_retired), 32'd1);
        cyc_a(1'b0, rnd_op(), ST_FETCH, "to_fetch_w2");
        cyc_a(1'b1, rnd_op(), ST_FETCH, "to_fetch");
        cyc_a(1'b1, LW, ST_DECODE, "to_decode");
        cyc_a(1'b1, rnd_op(), ST_MEMADR, "to_memadr");
        for (int i = 0; i < 4; i++) cyc_a(1'b0, rnd_op(), ST_MEMRD, "to_memrd_wait");
        cyc_a(1'b1, rnd_op(), ST_TRAP, "memrd_timeout");
        check_val("cause_memrd_timeout", 32'(a_cause), 32'(CAUSE_TIMEOUT));
        check_val("ret_no_partial", 32'(a_retired), 32'd1);

        do_reset("reset2");
        // illegal opcode: trap, then 20 quiet cycles
        cyc_a(1'b1, rnd_op(), ST_FETCH, "ill_fetch");
        cyc_a(1'b1, 7'b0000000, ST_DECODE, "ill_decode");
        cyc_a(1'b1, rnd_op(), ST_TRAP, "ill_trap");
        check_val("cause_illegal", 32'(a_cause), 32'(CAUSE_ILLEGAL));
        for (int i = 0; i < 20; i++)
            cyc_a(1'($urandom_range(0, 1)), rnd_op(), ST_TRAP, "ill_trap_hold");
        check_val("ret_after_trap", 32'(a_retired), 32'd0);
        check_val("cause_sticky", 32'(a_cause), 32'(CAUSE_ILLEGAL));

        // ---------------- report ----------------
        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
